alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 210 +++++++++++++++++++++
 tb/tb_alu_issue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Two-stage issue/writeback front end for a MIPS R-type ALU.
// S1 holds decoded operands for an external combinational ALU. S2 holds the
// ALU result until the writeback consumer accepts it. Operands are forwarded
// from S1 (live ALU result) and from S2 (pending writeback data).
module alu_issue #(
    parameter int N = 31
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instr,
    output logic [4:0]   rs_addr,
    output logic [4:0]   rt_addr,
    input  logic [N:0]   rs_data,
    input  logic [N:0]   rt_data,
    output logic [N:0]   alu_a,
    output logic [N:0]   alu_b,
    output logic [5:0]   alu_op,
    input  logic [N:0]   alu_result,
    output logic         wb_valid,
    input  logic         wb_ready,
    output logic [4:0]   wb_addr,
    output logic [N:0]   wb_data,
    output logic         wb_we,
    output logic         err,
    output logic [15:0]  retired
);

    localparam int W = N + 1;

    // Pipeline state
    logic         s1_valid_q, s1_valid_d;
    logic [4:0]   s1_rd_q,    s1_rd_d;
    logic [N:0]   alu_a_q,    alu_a_d;
    logic [N:0]   alu_b_q,    alu_b_d;
    logic [5:0]   alu_op_q,   alu_op_d;
    logic         s2_valid_q, s2_valid_d;
    logic [4:0]   wb_addr_q,  wb_addr_d;
    logic [N:0]   wb_data_q,  wb_data_d;
    logic         wb_we_q,    wb_we_d;
    logic         err_q,      err_d;
    logic [15:0]  retired_q,  retired_d;

    // Handshake and decode signals
    logic         s1_move_s;
    logic         accept_s;
    logic         wb_fire_s;
    logic         legal_s;
    logic [N:0]   rs_val_s;
    logic [N:0]   rt_val_s;

    // Only opcode 0 with one of the supported function codes is executable.
    function automatic logic is_legal(input logic [31:0] ins);
        logic ok;
        case (ins[5:0])
            6'b100001, 6'b100011, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b101010,
            6'b000000, 6'b000010, 6'b000011,
            6'b000100, 6'b000110, 6'b000111: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok && (ins[31:26] == 6'b000000);
    endfunction

    function automatic logic is_shift_imm(input logic [5:0] fn);
        return (fn == 6'b000000) || (fn == 6'b000010) || (fn == 6'b000011);
    endfunction

    function automatic logic is_shift_var(input logic [5:0] fn);
        return (fn == 6'b000100) || (fn == 6'b000110) || (fn == 6'b000111);
    endfunction

    // Youngest in-flight producer wins; register $0 is never forwarded.
    function automatic logic [N:0] fwd(
        input logic [4:0] src,
        input logic [N:0] rf_val,
        input logic       s1_v,
        input logic [4:0] s1_rd,
        input logic [N:0] s1_res,
        input logic       s2_v,
        input logic [4:0] s2_rd,
        input logic [N:0] s2_res
    );
        logic [N:0] v;
        if (s1_v && (s1_rd == src) && (src != 5'd0)) begin
            v = s1_res;
        end else if (s2_v && (s2_rd == src) && (src != 5'd0)) begin
            v = s2_res;
        end else begin
            v = rf_val;
        end
        return v;
    endfunction

    assign rs_addr   = instr[25:21];
    assign rt_addr   = instr[20:16];
    assign s1_move_s = s1_valid_q && (!s2_valid_q || wb_ready);
    assign in_ready  = !s1_valid_q || s1_move_s;
    assign accept_s  = in_valid && in_ready;
    assign wb_fire_s = s2_valid_q && wb_ready;
    assign legal_s   = is_legal(instr);

    assign rs_val_s = fwd(rs_addr, rs_data, s1_valid_q, s1_rd_q, alu_result,
                          s2_valid_q, wb_addr_q, wb_data_q);
    assign rt_val_s = fwd(rt_addr, rt_data, s1_valid_q, s1_rd_q, alu_result,
                          s2_valid_q, wb_addr_q, wb_data_q);

    // Next-state logic for both stages, the error flag and the retire counter.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_rd_d    = s1_rd_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        s2_valid_d = s2_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        wb_we_d    = wb_we_q;
        err_d      = err_q;
        retired_d  = retired_q;

        // S1: a legal accept reloads it; otherwise a departing entry leaves a bubble.
        if (accept_s && legal_s) begin
            s1_valid_d = 1'b1;
            s1_rd_d    = instr[15:11];
            alu_op_d   = instr[5:0];
            if (is_shift_imm(instr[5:0])) begin
                alu_a_d = rt_val_s;
                alu_b_d = {{(W-11){1'b0}}, instr[10:6], 6'b000000};
            end else if (is_shift_var(instr[5:0])) begin
                alu_a_d = rt_val_s;
                alu_b_d = rs_val_s;
            end else begin
                alu_a_d = rs_val_s;
                alu_b_d = rt_val_s;
            end
        end else if (s1_move_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        // Illegal words are consumed and flagged, never issued.
        if (accept_s && !legal_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        // S2: capture the live ALU result as S1 drains into it.
        if (s1_move_s) begin
            s2_valid_d = 1'b1;
            wb_addr_d  = s1_rd_q;
            wb_data_d  = alu_result;
            wb_we_d    = (s1_rd_q != 5'd0);
        end else if (wb_fire_s) begin
            s2_valid_d = 1'b0;
            wb_we_d    = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end

        if (wb_fire_s) begin
            retired_d = retired_q + 16'd1;
        end else begin
            retired_d = retired_q;
        end
    end

    // State registers with synchronous reset that overrides every event.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_rd_q    <= 5'd0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= 6'd0;
            s2_valid_q <= 1'b0;
            wb_addr_q  <= 5'd0;
            wb_data_q  <= '0;
            wb_we_q    <= 1'b0;
            err_q      <= 1'b0;
            retired_q  <= 16'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_rd_q    <= s1_rd_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            s2_valid_q <= s2_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_we_q    <= wb_we_d;
            err_q      <= err_d;
            retired_q  <= retired_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign wb_valid = s2_valid_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign wb_we    = wb_we_q;
    assign err      = err_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU on alu_result.
module tb_alu_issue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_op;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        err;
    logic [15:0] retired;

    int checks   = 0;
    int failures = 0;

    alu_issue #(.N(31)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_result(alu_result), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_we(wb_we), .err(err), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU behaviour: shift-immediate amount sits at b[10:6].
    always_comb begin
        case (alu_op)
            6'b100001: alu_result = alu_a + alu_b;
            6'b100011: alu_result = alu_a - alu_b;
            6'b100100: alu_result = alu_a & alu_b;
            6'b100101: alu_result = alu_a | alu_b;
            6'b100110: alu_result = alu_a ^ alu_b;
            6'b100111: alu_result = ~(alu_a | alu_b);
            6'b101010: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            6'b000000: alu_result = alu_a << alu_b[10:6];
            6'b000010: alu_result = alu_a >> alu_b[10:6];
            6'b000011: alu_result = 32'($signed(alu_a) >>> alu_b[10:6]);
            6'b000100: alu_result = alu_a << alu_b[4:0];
            6'b000110: alu_result = alu_a >> alu_b[4:0];
            6'b000111: alu_result = 32'($signed(alu_a) >>> alu_b[4:0]);
            default:   alu_result = 32'd0;
        endcase
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        instr    = 32'd0;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        wb_ready = 1'b1;
        step();
        step();
        check("rst_alu_a",   32'(alu_a),    32'd0);
        check("rst_alu_op",  32'(alu_op),   32'd0);
        check("rst_wb_valid",32'(wb_valid), 32'd0);
        check("rst_wb_we",   32'(wb_we),    32'd0);
        check("rst_err",     32'(err),      32'd0);
        check("rst_retired", 32'(retired),  32'd0);
        reset = 1'b0;
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // ADDU $3 = $1 + $2
        instr    = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100001);
        rs_data  = 32'd5;
        rt_data  = 32'd7;
        in_valid = 1'b1;
        #1;
        check("addu_rs_addr", 32'(rs_addr), 32'd1);
        check("addu_rt_addr", 32'(rt_addr), 32'd2);
        step();
        in_valid = 1'b0;
        check("addu_alu_a",  alu_a,         32'd5);
        check("addu_alu_b",  alu_b,         32'd7);
        check("addu_alu_op", 32'(alu_op),   32'h21);
        check("addu_no_wb",  32'(wb_valid), 32'd0);
        step();
        check("addu_wb_valid", 32'(wb_valid), 32'd1);
        check("addu_wb_addr",  32'(wb_addr),  32'd3);
        check("addu_wb_data",  wb_data,       32'd12);
        check("addu_wb_we",    32'(wb_we),    32'd1);
        step();
        check("addu_retired", 32'(retired), 32'd1);

        // SLL $4 = $2 << 3
        instr    = rtype(5'd0, 5'd2, 5'd4, 5'd3, 6'b000000);
        rs_data  = 32'd0;
        rt_data  = 32'd1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("sll_alu_a", alu_a, 32'd1);
        check("sll_alu_b", alu_b, 32'h000000C0);
        step();
        check("sll_wb_data", wb_data, 32'd8);
        check("sll_wb_addr", 32'(wb_addr), 32'd4);
        step();

        // Forwarding chain: ADDU $3, SUBU $5=$3-$1, OR $6=$3|$0
        instr    = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100001);
        rs_data  = 32'd5;
        rt_data  = 32'd7;
        in_valid = 1'b1;
        step();
        instr   = rtype(5'd3, 5'd1, 5'd5, 5'd0, 6'b100011);
        rs_data = 32'd0;
        rt_data = 32'd5;
        #1;
        check("fwd_in_ready", 32'(in_ready), 32'd1);
        step();
        check("fwd_s1_alu_a", alu_a, 32'd12);
        check("fwd_s1_alu_b", alu_b, 32'd5);
        check("fwd_s1_op",    32'(alu_op), 32'h23);
        instr   = rtype(5'd3, 5'd0, 5'd6, 5'd0, 6'b100101);
        rs_data = 32'd0;
        rt_data = 32'd0;
        step();
        in_valid = 1'b0;
        check("fwd_s2_alu_a",  alu_a,   32'd12);
        check("fwd_subu_wb",   wb_data, 32'd7);
        check("fwd_subu_addr", 32'(wb_addr), 32'd5);
        step();
        check("fwd_or_wb",     wb_data, 32'd12);
        check("fwd_or_addr",   32'(wb_addr), 32'd6);
        step();
        check("fwd_retired", 32'(retired), 32'd5);

        // Backpressure: three offered, two held
        wb_ready = 1'b0;
        instr    = rtype(5'd1, 5'd2, 5'd7, 5'd0, 6'b100001);
        rs_data  = 32'd1;
        rt_data  = 32'd2;
        in_valid = 1'b1;
        step();
        instr   = rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'b100001);
        rs_data = 32'd10;
        rt_data = 32'd20;
        step();
        instr   = rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'b100001);
        rs_data = 32'd100;
        rt_data = 32'd200;
        #1;
        check("bp_in_ready0", 32'(in_ready), 32'd0);
        step();
        check("bp_alu_a_hold", alu_a, 32'd10);
        check("bp_wb_hold",    wb_data, 32'd3);
        step();
        check("bp_alu_b_hold", alu_b, 32'd20);
        check("bp_in_ready1",  32'(in_ready), 32'd0);
        check("bp_wb_addr",    32'(wb_addr), 32'd7);
        wb_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_wb2_data", wb_data, 32'd30);
        check("bp_wb2_addr", 32'(wb_addr), 32'd8);
        check("bp_c_alu_a",  alu_a, 32'd100);
        step();
        check("bp_wb3_data", wb_data, 32'd300);
        check("bp_wb3_addr", 32'(wb_addr), 32'd9);
        step();
        check("bp_drained", 32'(wb_valid), 32'd0);
        check("bp_retired", 32'(retired), 32'd8);

        // Illegal instructions: J opcode, then JR funct
        instr    = {6'b000010, 26'd0};
        in_valid = 1'b1;
        #1;
        check("ill_in_ready", 32'(in_ready), 32'd1);
        step();
        check("ill_err", 32'(err), 32'd1);
        instr = rtype(5'd1, 5'd0, 5'd0, 5'd0, 6'b001000);
        step();
        in_valid = 1'b0;
        step();
        check("ill_no_wb",   32'(wb_valid), 32'd0);
        check("ill_retired", 32'(retired), 32'd8);
        instr    = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100001);
        rs_data  = 32'd2;
        rt_data  = 32'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("ill_after_wb",  wb_data, 32'd5);
        check("ill_err_stick", 32'(err), 32'd1);
        step();
        check("ill_after_ret", 32'(retired), 32'd9);

        // rd = 0 flows with no write enable
        instr    = rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'b100001);
        rs_data  = 32'd5;
        rt_data  = 32'd6;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("rd0_wb_valid", 32'(wb_valid), 32'd1);
        check("rd0_wb_we",    32'(wb_we),    32'd0);
        check("rd0_wb_data",  wb_data,       32'd11);
        step();
        check("rd0_retired", 32'(retired), 32'd10);

        // SRLV $10 = $2 >> $1: rt to alu_a, rs to alu_b
        instr    = rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'b000110);
        rs_data  = 32'd2;
        rt_data  = 32'h80;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("srlv_alu_a", alu_a, 32'h80);
        check("srlv_alu_b", alu_b, 32'd2);
        step();
        check("srlv_wb_data", wb_data, 32'h20);
        step();

        // Reset with both stages occupied
        wb_ready = 1'b0;
        instr    = rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'b100001);
        in_valid = 1'b1;
        step();
        instr = rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'b100001);
        step();
        in_valid = 1'b0;
        check("pre_rst_wb_valid", 32'(wb_valid), 32'd1);
        reset = 1'b1;
        step();
        reset    = 1'b0;
        wb_ready = 1'b1;
        check("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
        check("mid_rst_err",      32'(err),      32'd0);
        check("mid_rst_retired",  32'(retired),  32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        step();
        check("post_rst_wb_valid", 32'(wb_valid), 32'd0);
        check("post_rst_retired",  32'(retired),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
